// File: rtl/layer4_act_loader.sv
// layer4_act_loader: serial-to-parallel activation feeder for a layer-4 node bank, with a latency-timed result strobe.
// Ports: clk, reset (async, active-low); s_data/s_valid/s_last/s_ready form the serial word stream;
// A0x..A14x hold the parallel activations; frame_valid flags a loaded frame; res_valid pulses once the
// node bank has settled; err_short/err_long are sticky framing errors.
module layer4_act_loader #(
  parameter int N_IN = 15,
  parameter int DATA_W = 16,
  parameter int NODE_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] A0x,
  output logic [DATA_W-1:0] A1x,
  output logic [DATA_W-1:0] A2x,
  output logic [DATA_W-1:0] A3x,
  output logic [DATA_W-1:0] A4x,
  output logic [DATA_W-1:0] A5x,
  output logic [DATA_W-1:0] A6x,
  output logic [DATA_W-1:0] A7x,
  output logic [DATA_W-1:0] A8x,
  output logic [DATA_W-1:0] A9x,
  output logic [DATA_W-1:0] A10x,
  output logic [DATA_W-1:0] A11x,
  output logic [DATA_W-1:0] A12x,
  output logic [DATA_W-1:0] A13x,
  output logic [DATA_W-1:0] A14x,
  output logic              frame_valid,
  output logic              res_valid,
  output logic              err_short,
  output logic              err_long
);
  logic [3:0]        wr_idx;
  logic [3:0]        settle_cnt;
  logic [DATA_W-1:0] staging [N_IN];
  logic [DATA_W-1:0] act [N_IN];
  logic              accept;
  logic              xfer;
  assign s_ready = wr_idx < 4'(N_IN);
  assign accept = s_valid && s_ready;
  // A full staging buffer moves to the outputs only once the previous frame has finished settling.
  assign xfer = !s_ready && settle_cnt == 4'd0;
  always_ff @(posedge clk)
    if (accept) staging[wr_idx] <= s_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_idx <= '0;
      settle_cnt <= '0;
      frame_valid <= 1'b0;
      res_valid <= 1'b0;
      err_short <= 1'b0;
      err_long <= 1'b0;
      for (int i = 0; i < N_IN; i++) act[i] <= '0;
    end else begin
      res_valid <= settle_cnt == 4'd1;
      if (xfer) begin
        act <= staging;
        wr_idx <= '0;
        settle_cnt <= 4'(NODE_LAT);
        frame_valid <= 1'b1;
      end else if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
      // accept and xfer are mutually exclusive: one needs wr_idx<15, the other wr_idx==15.
      if (accept) begin
        if (s_last && wr_idx < 4'(N_IN - 1)) begin
          err_short <= 1'b1;
          wr_idx <= '0;
        end else begin
          wr_idx <= wr_idx + 4'd1;
          if (wr_idx == 4'(N_IN - 1) && !s_last) err_long <= 1'b1;
        end
      end
    end
  assign A0x = act[0];
  assign A1x = act[1];
  assign A2x = act[2];
  assign A3x = act[3];
  assign A4x = act[4];
  assign A5x = act[5];
  assign A6x = act[6];
  assign A7x = act[7];
  assign A8x = act[8];
  assign A9x = act[9];
  assign A10x = act[10];
  assign A11x = act[11];
  assign A12x = act[12];
  assign A13x = act[13];
  assign A14x = act[14];
endmodule

// File: tb/tb_layer4_act_loader.sv
// tb_layer4_act_loader: directed and random checks of layer4_act_loader (NODE_LAT 3 and 12) against a frame-level model.
module tb_layer4_act_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready, frame_valid, res_valid, err_short, err_long;
  logic        s_ready12, frame_valid12, res_valid12, err_short12, err_long12;
  logic [15:0] a [15];
  logic [15:0] a12 [15];
  int          total = 0;
  int          passed = 0;
  int          fails = 0;
  logic [15:0] q [$];
  logic [15:0] ea [15];
  bit          full, has_tx, efv, eshort, elong;
  int          cyc = 0;
  int          tx = 0;
  int          rv_count = 0;
  bit          acc;

  always #5 clk = ~clk;

  layer4_act_loader #(.NODE_LAT(3)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .A0x(a[0]), .A1x(a[1]), .A2x(a[2]), .A3x(a[3]), .A4x(a[4]), .A5x(a[5]), .A6x(a[6]), .A7x(a[7]),
    .A8x(a[8]), .A9x(a[9]), .A10x(a[10]), .A11x(a[11]), .A12x(a[12]), .A13x(a[13]), .A14x(a[14]),
    .frame_valid(frame_valid), .res_valid(res_valid), .err_short(err_short), .err_long(err_long));

  layer4_act_loader #(.NODE_LAT(12)) dut12 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready12),
    .A0x(a12[0]), .A1x(a12[1]), .A2x(a12[2]), .A3x(a12[3]), .A4x(a12[4]), .A5x(a12[5]), .A6x(a12[6]),
    .A7x(a12[7]), .A8x(a12[8]), .A9x(a12[9]), .A10x(a12[10]), .A11x(a12[11]), .A12x(a12[12]),
    .A13x(a12[13]), .A14x(a12[14]),
    .frame_valid(frame_valid12), .res_valid(res_valid12), .err_short(err_short12), .err_long(err_long12));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    full = 0;
    has_tx = 0;
    efv = 0;
    eshort = 0;
    elong = 0;
    for (int k = 0; k < 15; k++) ea[k] = '0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":s_ready"}, 32'(s_ready), 32'(!full));
    chk({ph, ":res_valid"}, 32'(res_valid), 32'(has_tx && cyc == tx + 3));
    chk({ph, ":frame_valid"}, 32'(frame_valid), 32'(efv));
    chk({ph, ":err_short"}, 32'(err_short), 32'(eshort));
    chk({ph, ":err_long"}, 32'(err_long), 32'(elong));
    chk({ph, ":s_ready12"}, 32'(s_ready12), 32'(!full));
    chk({ph, ":res_valid12"}, 32'(res_valid12), 32'(has_tx && cyc == tx + 12));
    chk({ph, ":frame_valid12"}, 32'(frame_valid12), 32'(efv));
    chk({ph, ":errs12"}, {30'b0, err_short12, err_long12}, {30'b0, eshort, elong});
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("%s:A%0dx", ph, k), 32'(a[k]), 32'(ea[k]));
      chk($sformatf("%s:A%0dx_lat12", ph, k), 32'(a12[k]), 32'(ea[k]));
    end
  endtask

  // One clock edge: inputs driven after the previous negedge, model advanced at the edge, outputs checked at the next negedge.
  task automatic step(input string ph, input bit v, input logic [15:0] d, input bit l, output bit accepted);
    bit xfer;
    s_valid = v;
    s_data = d;
    s_last = l;
    accepted = v && !full;
    @(posedge clk);
    cyc++;
    // A full frame moves out once the slower instance's settle window has closed; refilling takes
    // at least 15 edges, so this never actually stalls for either latency.
    xfer = full && (!has_tx || cyc >= tx + 13);
    if (xfer) begin
      for (int k = 0; k < 15; k++) ea[k] = q[k];
      q.delete();
      full = 0;
      tx = cyc;
      has_tx = 1;
      efv = 1;
    end
    if (accepted) begin
      q.push_back(d);
      if (l && q.size() < 15) begin
        eshort = 1;
        q.delete();
      end else if (q.size() == 15) begin
        full = 1;
        if (!l) elong = 1;
      end
    end
    @(negedge clk);
    if (res_valid) rv_count++;
    check_all(ph);
  endtask

  task automatic send_word(input string ph, input logic [15:0] d, input bit l);
    bit ok;
    int guard;
    ok = 0;
    guard = 0;
    while (!ok && guard < 40) begin
      step(ph, 1, d, l, ok);
      guard++;
    end
    if (!ok) chk({ph, ":accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle(input string ph, input int n);
    bit dummy;
    for (int i = 0; i < n; i++) step(ph, 0, 16'h0, 0, dummy);
  endtask

  initial begin
    reset = 0;
    s_valid = 0;
    s_data = 0;
    s_last = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    reset = 1;
    #1 check_all("release");

    for (int k = 0; k < 15; k++) send_word("f1", 16'(k + 1), k == 14);
    idle("f1x", 1);
    chk("f1:A0x", 32'(a[0]), 32'd1);
    chk("f1:A14x", 32'(a[14]), 32'd15);
    chk("f1:frame_valid", 32'(frame_valid), 32'd1);
    rv_count = 0;
    idle("f1s", 2);
    chk("f1:rv_early", 32'(res_valid), 32'd0);
    idle("f1s", 1);
    chk("f1:rv_T+4", 32'(res_valid), 32'd1);
    idle("f1s", 1);
    chk("f1:rv_one_cycle", 32'(res_valid), 32'd0);
    idle("f1s", 12);

    rv_count = 0;
    for (int k = 0; k < 15; k++) send_word("b2a", 16'(k + 1), k == 14);
    for (int k = 0; k < 15; k++) send_word("b2b", 16'(100 + k), k == 14);
    idle("b2x", 1);
    chk("b2:A0x", 32'(a[0]), 32'd100);
    chk("b2:A14x", 32'(a[14]), 32'd114);
    idle("b2s", 15);
    chk("b2:rv_pulses", 32'(rv_count), 32'd2);

    for (int k = 0; k < 6; k++) send_word("sh", k == 5 ? 16'h7FFF : 16'(k + 50), k == 5);
    chk("sh:err_short", 32'(err_short), 32'd1);
    chk("sh:no_xfer_A0x", 32'(a[0]), 32'd100);
    for (int k = 0; k < 15; k++) send_word("sh2", 16'h0010, k == 14);
    idle("sh2x", 1);
    chk("sh2:A5x", 32'(a[5]), 32'h10);

    for (int k = 0; k < 15; k++) send_word("lg", k == 14 ? 16'h8000 : 16'(k + 200), 0);
    chk("lg:err_long", 32'(err_long), 32'd1);
    idle("lgx", 1);
    chk("lg:A14x", 32'(a[14]), 32'h8000);
    idle("lgs", 14);

    for (int k = 0; k < 15; k++) send_word("r1", 16'(k + 300), k == 14);
    idle("r1x", 14);
    for (int k = 0; k < 8; k++) send_word("r2", 16'(k + 400), 0);
    @(posedge clk);
    #2 reset = 0;
    #1;
    model_reset();
    check_all("async_rst");
    s_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    reset = 1;
    #1 check_all("rst_rel");
    for (int k = 0; k < 15; k++) send_word("r3", 16'(k + 500), k == 14);
    idle("r3x", 14);
    chk("r3:A7x", 32'(a[7]), 32'd507);

    for (int i = 0; i < 600; i++) begin
      bit v, l;
      v = ($urandom % 4) != 0;
      l = (q.size() == 14) ? (($urandom % 8) != 0) : (($urandom % 25) == 0);
      step("rnd", v, 16'($urandom), l, acc);
    end
    idle("tail", 20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
